// File: rtl/test_result_monitor.sv
// Bus-snooping end-of-test monitor: captures the result byte, detects a
// jump-to-self trap or a run timeout, and reports done/pass/fail/timeout.
module test_result_monitor #(
  parameter logic [15:0] RESULT_ADDR = 16'h0071,
  parameter logic [7:0]  EXPECT_VAL  = 8'hFF,
  parameter int          TRAP_REPEAT = 3,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          CYC_W       = 16
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic [15:0]      address,
  input  logic [7:0]       data,
  input  logic             memwrite,
  input  logic             sync,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [7:0]       result,
  output logic             result_valid,
  output logic [CYC_W-1:0] cycles,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]       TRAP_N   = 4'(TRAP_REPEAT);
  localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};

  state_t           r_state;
  logic [15:0]      r_last_addr;
  logic [3:0]       r_trap_cnt;
  logic [7:0]       r_result;
  logic             r_result_valid;
  logic [CYC_W-1:0] r_cycles;
  logic             r_done, r_pass, r_fail, r_timeout;

  logic             w_capture;
  logic [7:0]       w_result_nxt;
  logic             w_valid_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_trap;
  logic             w_tmo;
  logic             w_pass_nxt;
  logic [CYC_W-1:0] w_cycles_inc;

  always_comb begin
    w_capture    = memwrite && (address == RESULT_ADDR) && (r_state != S_DONE);
    w_result_nxt = w_capture ? data : r_result;
    w_valid_nxt  = w_capture | r_result_valid;
    w_cnt_nxt    = r_trap_cnt;
    if (sync) begin
      if (address == r_last_addr)
        w_cnt_nxt = (r_trap_cnt == 4'hF) ? 4'hF : r_trap_cnt + 4'd1;
      else
        w_cnt_nxt = 4'd1;
    end
    w_trap       = (r_state == S_RUN) && sync && (w_cnt_nxt == TRAP_N);
    w_tmo        = (r_state == S_RUN) && (r_cycles == TMO_LAST);
    // Pass uses the post-capture result so a write in the trap cycle counts.
    w_pass_nxt   = w_valid_nxt && (w_result_nxt == EXPECT_VAL);
    w_cycles_inc = (r_cycles == CYC_MAX) ? r_cycles : r_cycles + 1'b1;
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_last_addr    <= 16'h0000;
      r_trap_cnt     <= 4'd0;
      r_result       <= 8'h00;
      r_result_valid <= 1'b0;
      r_cycles       <= '0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_fail         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_result       <= w_result_nxt;
      r_result_valid <= w_valid_nxt;
      case (r_state)
        S_IDLE: begin
          if (sync) begin
            r_state     <= S_RUN;
            r_last_addr <= address;
            r_trap_cnt  <= 4'd1;
          end
        end
        S_RUN: begin
          r_cycles    <= w_cycles_inc;
          r_trap_cnt  <= w_cnt_nxt;
          if (sync) r_last_addr <= address;
          // A trap on the final timeout cycle takes precedence.
          if (w_trap) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
            r_pass    <= w_pass_nxt;
            r_fail    <= !w_pass_nxt;
          end else if (w_tmo) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_fail    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign timeout      = r_timeout;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign cycles       = r_cycles;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor: pass, wrong value, missing result,
// timeout, trap/timeout collision, trap restart, reset and post-done capture.
module tb_test_result_monitor;

  localparam int CYC_W = 16;

  logic             ph1 = 1'b0;
  logic             reset;
  logic [15:0]      address;
  logic [7:0]       data;
  logic             memwrite;
  logic             sync;
  logic             done, pass, fail, timeout;
  logic [7:0]       result;
  logic             result_valid;
  logic [CYC_W-1:0] cycles;
  logic [1:0]       dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  test_result_monitor #(
    .RESULT_ADDR(16'h0071),
    .EXPECT_VAL (8'hFF),
    .TRAP_REPEAT(3),
    .TIMEOUT_CYC(64),
    .CYC_W      (CYC_W)
  ) dut (
    .ph1         (ph1),
    .reset       (reset),
    .address     (address),
    .data        (data),
    .memwrite    (memwrite),
    .sync        (sync),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .result      (result),
    .result_valid(result_valid),
    .cycles      (cycles),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 ph1 = ~ph1;

  // One bus cycle; outputs are sampled 1 time unit after the edge.
  task automatic bus(input logic s, input logic [15:0] a, input logic w, input logic [7:0] d);
    sync = s; address = a; memwrite = w; data = d;
    @(posedge ph1);
    #1;
    sync = 1'b0; memwrite = 1'b0; address = 16'h0000; data = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge ph1);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic d, input logic p, input logic f, input logic t);
    chk({tag, ".done"},    32'(done),    32'(d));
    chk({tag, ".pass"},    32'(pass),    32'(p));
    chk({tag, ".fail"},    32'(fail),    32'(f));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  // Scenario 1 body: two fetches, optional result write, trap at 0xF010 -> 7 RUN cycles.
  task automatic scenario_trap(input logic [7:0] val);
    bus(1'b1, 16'hF000, 1'b0, 8'h00);
    bus(1'b1, 16'hF002, 1'b0, 8'h00);
    bus(1'b0, 16'h0071, 1'b1, val);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    bus(1'b0, 16'h0000, 1'b0, 8'h00);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    bus(1'b0, 16'h0000, 1'b0, 8'h00);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b0; address = 16'h0000; data = 8'h00; memwrite = 1'b0; sync = 1'b0;

    // reset state
    do_reset();
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.result", 32'(result), 32'h00);
    chk("rst.rvalid", 32'(result_valid), 32'h0);
    chk("rst.cycles", 32'(cycles), 32'd0);
    chk("rst.state",  32'(dbg_state), 32'd0);

    // 1: normal pass
    scenario_trap(8'hFF);
    chk_flags("t1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1.result", 32'(result), 32'hFF);
    chk("t1.rvalid", 32'(result_valid), 32'h1);
    chk("t1.cycles", 32'(cycles), 32'd7);
    chk("t1.state",  32'(dbg_state), 32'd2);
    bus(1'b0, 16'h0000, 1'b0, 8'h00);
    chk("t1.cycles_frozen", 32'(cycles), 32'd7);

    // 2: wrong value
    do_reset();
    scenario_trap(8'hFE);
    chk_flags("t2", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2.result", 32'(result), 32'hFE);

    // 3: no result write
    do_reset();
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    bus(1'b0, 16'h0000, 1'b0, 8'h00);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    bus(1'b0, 16'h0000, 1'b0, 8'h00);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    chk_flags("t3", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3.rvalid", 32'(result_valid), 32'h0);
    chk("t3.result", 32'(result), 32'h00);
    chk("t3.cycles", 32'(cycles), 32'd4);

    // 4: timeout with ever-changing fetch addresses
    do_reset();
    for (int k = 0; k < 64; k++) bus(1'b1, 16'hF000 + 16'(2 * k), 1'b0, 8'h00);
    chk("t4.cycles63", 32'(cycles), 32'd63);
    chk("t4.done_pre", 32'(done), 32'd0);
    bus(1'b1, 16'hF000 + 16'd128, 1'b0, 8'h00);
    chk_flags("t4", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t4.cycles", 32'(cycles), 32'd64);
    bus(1'b1, 16'h1234, 1'b0, 8'h00);
    chk("t4.cycles_hold", 32'(cycles), 32'd64);

    // 5a: result write in the trap cycle (trap loop sits at the result address)
    do_reset();
    bus(1'b1, 16'h0071, 1'b0, 8'h00);
    bus(1'b0, 16'h0000, 1'b0, 8'h00);
    bus(1'b1, 16'h0071, 1'b0, 8'h00);
    bus(1'b0, 16'h0000, 1'b0, 8'h00);
    chk("t5a.rvalid_pre", 32'(result_valid), 32'h0);
    bus(1'b1, 16'h0071, 1'b1, 8'hFF);
    chk_flags("t5a", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5a.result", 32'(result), 32'hFF);

    // 5b: repeat count restarts on a different fetch
    do_reset();
    bus(1'b1, 16'hF020, 1'b0, 8'h00);
    bus(1'b1, 16'hF020, 1'b0, 8'h00);
    bus(1'b1, 16'hF030, 1'b0, 8'h00);
    bus(1'b1, 16'hF020, 1'b0, 8'h00);
    bus(1'b1, 16'hF020, 1'b0, 8'h00);
    chk("t5b.no_trap", 32'(done), 32'd0);
    chk("t5b.state",   32'(dbg_state), 32'd1);
    bus(1'b1, 16'hF020, 1'b0, 8'h00);
    chk_flags("t5b", 1'b1, 1'b0, 1'b1, 1'b0);

    // 5c: trap on the exact timeout cycle, result written while IDLE
    do_reset();
    bus(1'b0, 16'h0071, 1'b1, 8'hFF);
    chk("t5c.idle_capture", 32'(result), 32'hFF);
    for (int k = 0; k < 62; k++) bus(1'b1, 16'hA000 + 16'(2 * k), 1'b0, 8'h00);
    bus(1'b1, 16'hE000, 1'b0, 8'h00);
    bus(1'b1, 16'hE000, 1'b0, 8'h00);
    chk("t5c.cycles63", 32'(cycles), 32'd63);
    chk("t5c.done_pre", 32'(done), 32'd0);
    bus(1'b1, 16'hE000, 1'b0, 8'h00);
    chk_flags("t5c", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5c.cycles", 32'(cycles), 32'd64);

    // 6a: reset mid-run, IDLE ignores non-sync cycles
    do_reset();
    bus(1'b1, 16'hF000, 1'b0, 8'h00);
    bus(1'b1, 16'hF002, 1'b0, 8'h00);
    bus(1'b0, 16'h0071, 1'b1, 8'hFF);
    do_reset();
    chk_flags("t6a", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6a.result", 32'(result), 32'h00);
    chk("t6a.rvalid", 32'(result_valid), 32'h0);
    chk("t6a.cycles", 32'(cycles), 32'd0);
    for (int k = 0; k < 3; k++) bus(1'b0, 16'hF000, 1'b0, 8'h00);
    chk("t6a.idle_cycles", 32'(cycles), 32'd0);
    chk("t6a.idle_state",  32'(dbg_state), 32'd0);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    bus(1'b1, 16'hF010, 1'b0, 8'h00);
    chk_flags("t6a.trap", 1'b1, 1'b0, 1'b1, 1'b0);

    // 6b: reset from DONE then rerun scenario 1
    do_reset();
    chk("t6b.done_clr", 32'(done), 32'd0);
    scenario_trap(8'hFF);
    chk_flags("t6b", 1'b1, 1'b1, 1'b0, 1'b0);

    // 6c: writes after DONE are ignored
    bus(1'b0, 16'h0071, 1'b1, 8'h12);
    bus(1'b1, 16'h0071, 1'b1, 8'h34);
    chk("t6c.result", 32'(result), 32'hFF);
    chk("t6c.pass",   32'(pass), 32'd1);
    chk("t6c.cycles", 32'(cycles), 32'd7);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
